lifo_stack_controller: RTL

Command-sequencing front end for the 16-bit, 8-entry LIFO stack. It accepts push/pop/peek/clear commands over a valid/ready handshake and turns each into single-cycle stack strobes. It captures the stack's read data and returns one response per command over a second valid/ready handshake. It sits directly upstream of the stack, drives its Push/Pop/Peek/Data inputs and consumes its Data_Out/Empty/Full outputs.

---
 rtl/lifo_stack_controller_if.sv | 37 +++
 rtl/lifo_stack_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack_controller_if.sv
// ---------------------------------------------------------------------------
// lifo_stack_controller_if
//   Command / response handshake bundle for the LIFO stack controller.
//
//   Command channel (requester -> controller):
//     Cmd_Valid_In, Cmd_Op_In[1:0], Cmd_Data_In[DATA_WIDTH-1:0]
//     Cmd_Ready_Out (controller -> requester)
//   Response channel (controller -> requester):
//     Rsp_Valid_Out, Rsp_Data_Out[DATA_WIDTH-1:0], Rsp_Error_Out
//     Rsp_Ready_In (requester -> controller)
//
//   Modports:
//     master - the requester side (issues commands, consumes responses)
//     slave  - the controller side
// ---------------------------------------------------------------------------
interface lifo_stack_controller_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  Cmd_Valid_In;
    logic                  Cmd_Ready_Out;
    logic [1:0]            Cmd_Op_In;
    logic [DATA_WIDTH-1:0] Cmd_Data_In;
    logic                  Rsp_Valid_Out;
    logic                  Rsp_Ready_In;
    logic [DATA_WIDTH-1:0] Rsp_Data_Out;
    logic                  Rsp_Error_Out;

    modport master (
        output Cmd_Valid_In, Cmd_Op_In, Cmd_Data_In, Rsp_Ready_In,
        input  Cmd_Ready_Out, Rsp_Valid_Out, Rsp_Data_Out, Rsp_Error_Out
    );

    modport slave (
        input  Cmd_Valid_In, Cmd_Op_In, Cmd_Data_In, Rsp_Ready_In,
        output Cmd_Ready_Out, Rsp_Valid_Out, Rsp_Data_Out, Rsp_Error_Out
    );
endinterface

// File: rtl/lifo_stack_controller.sv
// ---------------------------------------------------------------------------
// lifo_stack_controller
//   Command-sequencing front end for a DATA_WIDTH x DEPTH LIFO stack.
//   Accepts PUSH/POP/PEEK/CLEAR commands, turns each into single-cycle
//   stack strobes, captures the stack read data and returns exactly one
//   response per command.
//
//   Ports:
//     Clk_In, Reset_In       clock, synchronous active-high reset
//     cmd_rsp_if (slave)     command and response valid/ready channels
//     Stack_Push_Out/Pop/Peek  one-hot strobes to the stack
//     Stack_Data_Out         latched command data presented to the stack
//     Stack_Data_In          stack read data
//     Stack_Empty_In/Full_In stack flags
//     Level_Out              tracked occupancy (0 when the counter is absent)
//
//   Build option:
//     LIFO_CTRL_LEVEL_EN     when defined, an occupancy counter drives
//                            Level_Out; otherwise Level_Out is tied to 0.
//
//   All outputs are registered. A response becomes visible on the same edge
//   the FSM enters RESP, so an error response is sampled one edge after the
//   command is accepted and a normal one two edges after.
// ---------------------------------------------------------------------------
module lifo_stack_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    lifo_stack_controller_if.slave cmd_rsp_if,
    output logic                  Stack_Push_Out,
    output logic                  Stack_Pop_Out,
    output logic                  Stack_Peek_Out,
    output logic [DATA_WIDTH-1:0] Stack_Data_Out,
    input  logic [DATA_WIDTH-1:0] Stack_Data_In,
    input  logic                  Stack_Empty_In,
    input  logic                  Stack_Full_In,
    output logic [3:0]            Level_Out
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_PEEK  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ready_q, ready_d;
    logic                  push_q, push_d;
    logic                  pop_q, pop_d;
    logic                  peek_q, peek_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
`ifdef LIFO_CTRL_LEVEL_EN
    logic [3:0]            level_q, level_d;
`endif

    logic cmd_fire;
    logic cmd_reject;

    assign cmd_fire   = cmd_rsp_if.Cmd_Valid_In && ready_q;
    // Rejection is decided from the flags at acceptance; no strobe is issued.
    assign cmd_reject = ((cmd_rsp_if.Cmd_Op_In == OP_PUSH) && Stack_Full_In) ||
                        (((cmd_rsp_if.Cmd_Op_In == OP_POP) ||
                          (cmd_rsp_if.Cmd_Op_In == OP_PEEK)) && Stack_Empty_In);
    assign cnt_inc    = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        ready_d     = ready_q;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        peek_d      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;
`ifdef LIFO_CTRL_LEVEL_EN
        level_d     = level_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    op_d    = cmd_rsp_if.Cmd_Op_In;
                    data_d  = cmd_rsp_if.Cmd_Data_In;
                    ready_d = 1'b0;
                    if (cmd_reject) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else if ((cmd_rsp_if.Cmd_Op_In == OP_CLEAR) && Stack_Empty_In) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = '0;
                    end else if (cmd_rsp_if.Cmd_Op_In == OP_CLEAR) begin
                        state_d = DRAIN;
                        pop_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ISSUE;
                        push_d  = (cmd_rsp_if.Cmd_Op_In == OP_PUSH);
                        pop_d   = (cmd_rsp_if.Cmd_Op_In == OP_POP);
                        peek_d  = (cmd_rsp_if.Cmd_Op_In == OP_PEEK);
                    end
                end
            end
            ISSUE: begin
                // Stack acted on the falling edge of the strobe cycle, so its
                // read data is valid at this edge.
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = (op_q == OP_PUSH) ? '0 : Stack_Data_In;
`ifdef LIFO_CTRL_LEVEL_EN
                if ((op_q == OP_PUSH) && (level_q != 4'(DEPTH)))
                    level_d = level_q + 4'd1;
                else if ((op_q == OP_POP) && (level_q != 4'd0))
                    level_d = level_q - 4'd1;
`endif
            end
            DRAIN: begin
                cnt_d = cnt_inc;
`ifdef LIFO_CTRL_LEVEL_EN
                if (level_q != 4'd0)
                    level_d = level_q - 4'd1;
`endif
                if (Stack_Empty_In) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = DATA_WIDTH'(cnt_inc);
                end else begin
                    pop_d = 1'b1;
                end
            end
            RESP: begin
                if (cmd_rsp_if.Rsp_Ready_In) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q     <= IDLE;
            op_q        <= OP_PUSH;
            data_q      <= '0;
            ready_q     <= 1'b1;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            peek_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
`ifdef LIFO_CTRL_LEVEL_EN
            level_q     <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            peek_q      <= peek_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
`ifdef LIFO_CTRL_LEVEL_EN
            level_q     <= level_d;
`endif
        end
    end

    assign cmd_rsp_if.Cmd_Ready_Out = ready_q;
    assign cmd_rsp_if.Rsp_Valid_Out = rsp_valid_q;
    assign cmd_rsp_if.Rsp_Error_Out = rsp_err_q;
    assign cmd_rsp_if.Rsp_Data_Out  = rsp_data_q;
    assign Stack_Push_Out           = push_q;
    assign Stack_Pop_Out            = pop_q;
    assign Stack_Peek_Out           = peek_q;
    assign Stack_Data_Out           = data_q;
`ifdef LIFO_CTRL_LEVEL_EN
    assign Level_Out                = level_q;
`else
    assign Level_Out                = 4'd0;
`endif

endmodule
